pan_feed_ctrl: RTL

PAN_FEED_CTRL -- requirements
Module: pan_feed_ctrl

---
 rtl/pan_feed_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pan_feed_ctrl.sv
// rtl/pan_feed_ctrl.sv - ASCII PAN character feed sequencer
// Turns an ASCII character stream into start/digit/end/abort strobes for a PAN checking datapath.
module pan_feed_ctrl #(
   parameter int MAX_DIGITS  = 19,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ch_valid,
   input  logic [7:0] ch_data,
   output logic       ch_ready,
   output logic       start,
   output logic       digit_valid,
   output logic [3:0] digit_in,
   output logic       pan_end,
   output logic       abort,
   input  logic       length_ok,
   input  logic       error_flag,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_code,
   output logic [4:0] digit_cnt
);

   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [4:0]    CNT_MAX  = 5'(MAX_DIGITS);

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_BAD_CHAR = 3'd1;
   localparam logic [2:0] FC_OVERLEN  = 3'd2;
   localparam logic [2:0] FC_TIMEOUT  = 3'd3;
   localparam logic [2:0] FC_LENGTH   = 3'd4;
   localparam logic [2:0] FC_DP_ERR   = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_DIGIT, S_GAP, S_RECV, S_END, S_SAMPLE, S_ABORT, S_DONE
   } state_t;

   state_t        state, next_state;
   logic [2:0]    abort_code;
   logic [3:0]    digit_q;
   logic [TW-1:0] tmo_cnt;

   logic accept, is_digit, is_sep, is_cr, in_stream;
   logic ready_d, start_d, digit_d, end_d, abort_d, busy_d, done_d;

   assign accept    = ch_valid & ch_ready;
   assign is_digit  = (ch_data >= 8'h30) && (ch_data <= 8'h39);
   assign is_sep    = (ch_data == 8'h20) || (ch_data == 8'h2D);
   assign is_cr     = (ch_data == 8'h0D);
   assign in_stream = (state == S_START) || (state == S_DIGIT) ||
                      (state == S_GAP)   || (state == S_RECV);

   // The idle counter only advances while waiting for a character in RECV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         tmo_cnt <= '0;
      end else begin
         state <= next_state;
         if (state != S_RECV || accept)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      abort_code = FC_NONE;
      case (state)
         S_IDLE:   if (accept && is_digit) next_state = S_START;
         S_START:  next_state = S_DIGIT;
         S_DIGIT:  next_state = S_GAP;
         S_GAP:    next_state = S_RECV;
         S_RECV: begin
            if (accept) begin
               if (is_digit) begin
                  if (digit_cnt >= CNT_MAX) begin
                     next_state = S_ABORT;
                     abort_code = FC_OVERLEN;
                  end else begin
                     next_state = S_DIGIT;
                  end
               end else if (is_sep) begin
                  next_state = S_RECV;
               end else if (is_cr) begin
                  next_state = S_END;
               end else begin
                  next_state = S_ABORT;
                  abort_code = FC_BAD_CHAR;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               next_state = S_ABORT;
               abort_code = FC_TIMEOUT;
            end
         end
         S_END:    next_state = S_SAMPLE;
         S_SAMPLE: next_state = S_DONE;
         S_ABORT:  next_state = S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
      // A datapath error outranks whatever the character or timer asked for.
      if (error_flag && in_stream) begin
         next_state = S_ABORT;
         abort_code = FC_DP_ERR;
      end
   end

   always_comb begin
      ready_d = (next_state == S_IDLE) || (next_state == S_RECV);
      start_d = (next_state == S_START);
      digit_d = (next_state == S_DIGIT);
      end_d   = (next_state == S_END);
      abort_d = (next_state == S_ABORT);
      done_d  = (next_state == S_DONE);
      busy_d  = (next_state != S_IDLE);
   end

   // Strobes are decoded from next_state so they appear registered, aligned with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_ready    <= 1'b0;
         start       <= 1'b0;
         digit_valid <= 1'b0;
         pan_end     <= 1'b0;
         abort       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         digit_in    <= 4'd0;
         digit_q     <= 4'd0;
         digit_cnt   <= 5'd0;
         pass        <= 1'b0;
         fail_code   <= FC_NONE;
      end else begin
         ch_ready    <= ready_d;
         start       <= start_d;
         digit_valid <= digit_d;
         pan_end     <= end_d;
         abort       <= abort_d;
         busy        <= busy_d;
         done        <= done_d;
         if (accept && is_digit)
            digit_q <= ch_data[3:0];
         if (digit_d) begin
            digit_in  <= (state == S_RECV) ? ch_data[3:0] : digit_q;
            digit_cnt <= digit_cnt + 5'd1;
         end
         if (state == S_IDLE && start_d) begin
            digit_cnt <= 5'd0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
         end
         if (abort_d && state != S_ABORT) begin
            pass      <= 1'b0;
            fail_code <= abort_code;
         end
         if (state == S_SAMPLE) begin
            if (error_flag) begin
               pass      <= 1'b0;
               fail_code <= FC_DP_ERR;
            end else if (!length_ok) begin
               pass      <= 1'b0;
               fail_code <= FC_LENGTH;
            end else begin
               pass      <= 1'b1;
               fail_code <= FC_NONE;
            end
         end
      end
   end

endmodule
